// File: rtl/mc_wr_unpack.sv
// mc_wr_unpack: write-data unpacker for the memory controller data path.
// Takes one 32-bit WB write word and presents it as 1, 2 or 4 memory-bus
// beats, depending on the chip-select bus width latched when the word is taken.
// Each beat carries lane byte enables and per-byte even parity.
//
// Handshakes:
//   Input side : a word transfers on a clock edge where wr_valid & wr_ready.
//                wr_ready is combinational and drops whenever clr is high.
//   Output side: a beat transfers on a clock edge where beat_valid & mc_beat_re.
//                While beat_valid & !mc_beat_re the beat outputs hold stable.
module mc_wr_unpack (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] csc,
  input  logic        clr,
  input  logic [31:0] wb_data_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        mc_beat_re,
  output logic        beat_valid,
  output logic        last_beat,
  output logic [31:0] mc_data_o,
  output logic [3:0]  mc_dp_o,
  output logic [3:0]  mc_be_o,
  output logic [0:0]  fsm_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [1:0] BW_8  = 2'b00;
  localparam logic [1:0] BW_16 = 2'b01;
  localparam logic [1:0] BW_32 = 2'b10;

  // Current holding state
  logic [0:0]  state;
  logic [31:0] word_q;
  logic [3:0]  sel_q;
  logic [1:0]  bw_q;
  logic        pen_q;
  logic [1:0]  cnt_q;
  logic [1:0]  last_idx_q;

  // Next holding state
  logic [0:0]  state_d;
  logic [31:0] word_d;
  logic [3:0]  sel_d;
  logic [1:0]  bw_d;
  logic        pen_d;
  logic [1:0]  cnt_d;
  logic [1:0]  last_idx_d;

  // Next beat contents, built from the next holding state so outputs are flops
  logic [31:0] nxt_data;
  logic [3:0]  nxt_dp;
  logic [3:0]  nxt_be;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  logic load;
  logic advance;
  logic unused_csc;

  assign fsm_state  = state;
  assign unused_csc = ^{csc[31:12], csc[10:6], csc[3:0]};

  // Accept a new word when idle, or in the same cycle the final beat leaves
  always_comb begin
    wr_ready = !clr && ((state == IDLE) || (beat_valid && mc_beat_re && last_beat));
    load     = wr_valid && wr_ready;
    advance  = beat_valid && mc_beat_re;
  end

  // Next-state logic: clr beats load, load beats advance
  always_comb begin
    state_d    = state;
    word_d     = word_q;
    sel_d      = sel_q;
    bw_d       = bw_q;
    pen_d      = pen_q;
    cnt_d      = cnt_q;
    last_idx_d = last_idx_q;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      word_d  = 32'h0;
      sel_d   = 4'h0;
    end else if (load) begin
      state_d = SEND;
      word_d  = wb_data_i;
      sel_d   = wb_sel_i;
      pen_d   = csc[11];
      cnt_d   = 2'd0;
      case (csc[5:4])
        BW_8:    begin bw_d = BW_8;  last_idx_d = 2'd3; end
        BW_16:   begin bw_d = BW_16; last_idx_d = 2'd1; end
        default: begin bw_d = BW_32; last_idx_d = 2'd0; end
      endcase
    end else if (advance) begin
      if (last_beat) begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // Beat formatting: select the lane for the next beat, right-justify it
  always_comb begin
    nxt_data = 32'h0;
    nxt_dp   = 4'h0;
    nxt_be   = 4'h0;
    case (cnt_d)
      2'd0:    lane_byte = word_d[7:0];
      2'd1:    lane_byte = word_d[15:8];
      2'd2:    lane_byte = word_d[23:16];
      default: lane_byte = word_d[31:24];
    endcase
    lane_half = cnt_d[0] ? word_d[31:16] : word_d[15:0];
    if (state_d == SEND) begin
      case (bw_d)
        BW_8: begin
          nxt_data = {24'h0, lane_byte};
          nxt_be   = {3'b000, sel_d[cnt_d]};
          nxt_dp   = {3'b000, ^lane_byte};
        end
        BW_16: begin
          nxt_data = {16'h0, lane_half};
          nxt_be   = {2'b00, (cnt_d[0] ? sel_d[3:2] : sel_d[1:0])};
          nxt_dp   = {2'b00, ^lane_half[15:8], ^lane_half[7:0]};
        end
        default: begin
          nxt_data = word_d;
          nxt_be   = sel_d;
          nxt_dp   = {^word_d[31:24], ^word_d[23:16], ^word_d[15:8], ^word_d[7:0]};
        end
      endcase
      if (!pen_d) nxt_dp = 4'h0;
    end
  end

  // Holding registers and FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      word_q     <= 32'h0;
      sel_q      <= 4'h0;
      bw_q       <= BW_32;
      pen_q      <= 1'b0;
      cnt_q      <= 2'd0;
      last_idx_q <= 2'd0;
    end else begin
      state      <= state_d;
      word_q     <= word_d;
      sel_q      <= sel_d;
      bw_q       <= bw_d;
      pen_q      <= pen_d;
      cnt_q      <= cnt_d;
      last_idx_q <= last_idx_d;
    end
  end

  // Registered beat outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_valid <= 1'b0;
      last_beat  <= 1'b0;
      mc_data_o  <= 32'h0;
      mc_dp_o    <= 4'h0;
      mc_be_o    <= 4'h0;
    end else begin
      beat_valid <= (state_d == SEND);
      last_beat  <= (state_d == SEND) && (cnt_d == last_idx_d);
      mc_data_o  <= nxt_data;
      mc_dp_o    <= nxt_dp;
      mc_be_o    <= nxt_be;
    end
  end

endmodule

// File: tb/tb_mc_wr_unpack.sv
// tb_mc_wr_unpack: directed bench for mc_wr_unpack. Expected beats are
// hand-computed and queued when a word is offered; a negedge monitor pops
// and compares each beat the memory side consumes.
module tb_mc_wr_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] csc;
  logic        clr;
  logic [31:0] wb_data_i;
  logic [3:0]  wb_sel_i;
  logic        wr_valid;
  logic        wr_ready;
  logic        mc_beat_re;
  logic        beat_valid;
  logic        last_beat;
  logic [31:0] mc_data_o;
  logic [3:0]  mc_dp_o;
  logic [3:0]  mc_be_o;
  logic [0:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // {last, be[3:0], dp[3:0], data[31:0]}
  logic [40:0] exp_q[$];
  logic [40:0] mon_e;

  mc_wr_unpack dut (
    .clk        (clk),
    .rst        (rst),
    .csc        (csc),
    .clr        (clr),
    .wb_data_i  (wb_data_i),
    .wb_sel_i   (wb_sel_i),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .mc_beat_re (mc_beat_re),
    .beat_valid (beat_valid),
    .last_beat  (last_beat),
    .mc_data_o  (mc_data_o),
    .mc_dp_o    (mc_dp_o),
    .mc_be_o    (mc_be_o),
    .fsm_state  (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk_csc(input logic [1:0] bw, input logic pen);
    mk_csc = {20'h0, pen, 5'h0, bw, 4'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic last, input logic [3:0] be, input logic [3:0] dp,
                      input logic [31:0] data);
    exp_q.push_back({last, be, dp, data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] bw, input logic pen, input logic [31:0] data,
                       input logic [3:0] sel);
    csc       = mk_csc(bw, pen);
    wb_data_i = data;
    wb_sel_i  = sel;
    wr_valid  = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats still expected, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compare every consumed beat against the scoreboard
  always @(negedge clk) begin
    if (!rst && beat_valid && mc_beat_re) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data 0x%0h, required no beat", mc_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", mc_data_o, mon_e[31:0]);
        check("beat_dp", 32'(mc_dp_o), 32'(mon_e[35:32]));
        check("beat_be", 32'(mc_be_o), 32'(mon_e[39:36]));
        check("beat_last", 32'(last_beat), 32'(mon_e[40]));
        if (mon_e[40]) check("ready_on_last", 32'(wr_ready), 32'd1);
      end
    end
  end

  initial begin
    rst        = 1'b1;
    csc        = 32'h0;
    clr        = 1'b0;
    wb_data_i  = 32'h0;
    wb_sel_i   = 4'h0;
    wr_valid   = 1'b0;
    mc_beat_re = 1'b1;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_valid", 32'(beat_valid), 32'd0);
    check("rst_data", mc_data_o, 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(wr_ready), 32'd1);
    check("idle_last", 32'(last_beat), 32'd0);
    check("idle_dp_be", 32'({mc_dp_o, mc_be_o}), 32'h0);
    check("idle_state", 32'(fsm_state), 32'd0);
    step();

    // BW_8, pen=1: four consecutive beats
    push(1'b0, 4'h1, 4'h0, 32'h0000_00D4);
    push(1'b0, 4'h1, 4'h0, 32'h0000_00C3);
    push(1'b0, 4'h1, 4'h0, 32'h0000_00B2);
    push(1'b1, 4'h1, 4'h1, 32'h0000_00A1);
    offer(2'b00, 1'b1, 32'hA1B2_C3D4, 4'hF);
    step();
    wr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bw8_consecutive", 32'(beat_valid), 32'd1);
      step();
    end
    drain("bw8");

    // BW_16, pen=0
    push(1'b0, 4'h0, 4'h0, 32'h0000_5678);
    push(1'b1, 4'h3, 4'h0, 32'h0000_1234);
    offer(2'b01, 1'b0, 32'h1234_5678, 4'hC);
    step();
    wr_valid = 1'b0;
    drain("bw16");

    // BW_16, pen=1: per-byte parity within each half
    push(1'b0, 4'h3, 4'h1, 32'h0000_0301);
    push(1'b1, 4'h3, 4'h3, 32'h0000_0107);
    offer(2'b01, 1'b1, 32'h0107_0301, 4'hF);
    step();
    wr_valid = 1'b0;
    drain("bw16_pen");

    // BW_32, pen=1: single beat, last on first valid cycle
    push(1'b1, 4'hA, 4'h1, 32'hFF00_FF01);
    offer(2'b10, 1'b1, 32'hFF00_FF01, 4'hA);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    check("bw32_last_first", 32'(last_beat), 32'd1);
    drain("bw32");

    // Width code 2'b11 behaves as 32-bit
    push(1'b1, 4'h6, 4'h8, 32'h8000_0003);
    offer(2'b11, 1'b1, 32'h8000_0003, 4'h6);
    step();
    wr_valid = 1'b0;
    drain("bw11");

    // Backpressure on beat 1, csc change in flight, back-to-back second word
    push(1'b0, 4'h0, 4'h0, 32'h0000_0011);
    push(1'b0, 4'h1, 4'h0, 32'h0000_0022);
    push(1'b0, 4'h0, 4'h0, 32'h0000_0033);
    push(1'b1, 4'h1, 4'h0, 32'h0000_0044);
    offer(2'b00, 1'b0, 32'h4433_2211, 4'hA);
    step();
    wr_valid = 1'b0;
    step();
    mc_beat_re = 1'b0;
    csc = mk_csc(2'b10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(beat_valid), 32'd1);
      check("stall_data", mc_data_o, 32'h0000_0022);
      check("stall_be_dp", 32'({mc_be_o, mc_dp_o}), 32'h10);
      check("stall_last", 32'(last_beat), 32'd0);
      step();
    end
    mc_beat_re = 1'b1;
    step();
    step();
    push(1'b0, 4'h1, 4'h1, 32'h0000_0002);
    push(1'b0, 4'h1, 4'h1, 32'h0000_0001);
    push(1'b0, 4'h1, 4'h1, 32'h0000_007F);
    push(1'b1, 4'h1, 4'h1, 32'h0000_0080);
    offer(2'b00, 1'b1, 32'h807F_0102, 4'hF);
    @(negedge clk);
    check("b2b_last_present", 32'(last_beat), 32'd1);
    check("b2b_ready", 32'(wr_ready), 32'd1);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_gap_valid", 32'(beat_valid), 32'd1);
    check("b2b_no_gap_data", mc_data_o, 32'h0000_0002);
    drain("b2b");

    // Abort during beat 2 with a competing word offered
    push(1'b0, 4'h1, 4'h0, 32'h0000_00D4);
    push(1'b0, 4'h1, 4'h0, 32'h0000_00C3);
    offer(2'b00, 1'b1, 32'hA1B2_C3D4, 4'hF);
    step();
    wr_valid = 1'b0;
    step();
    step();
    mc_beat_re = 1'b0;
    clr = 1'b1;
    offer(2'b00, 1'b1, 32'h5555_5555, 4'hF);
    @(negedge clk);
    check("abort_beat2_data", mc_data_o, 32'h0000_00B2);
    check("abort_ready_low", 32'(wr_ready), 32'd0);
    step();
    clr      = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(beat_valid), 32'd0);
    check("abort_data", mc_data_o, 32'h0);
    check("abort_ready", 32'(wr_ready), 32'd1);
    check("abort_state", 32'(fsm_state), 32'd0);
    mc_beat_re = 1'b1;
    drain("abort");
    step();
    @(negedge clk);
    check("abort_stays_idle", 32'(beat_valid), 32'd0);
    step();

    // Asynchronous reset during BW_16 beat 0
    offer(2'b01, 1'b1, 32'hCAFE_BABE, 4'hF);
    step();
    wr_valid   = 1'b0;
    mc_beat_re = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(beat_valid), 32'd1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(beat_valid), 32'd0);
    check("arst_last", 32'(last_beat), 32'd0);
    check("arst_data", mc_data_o, 32'h0);
    check("arst_dp_be", 32'({mc_dp_o, mc_be_o}), 32'h0);
    check("arst_ready", 32'(wr_ready), 32'd1);
    #3;
    rst = 1'b0;
    step();
    mc_beat_re = 1'b1;
    push(1'b0, 4'h3, 4'h1, 32'h0000_0301);
    push(1'b1, 4'h3, 4'h3, 32'h0000_0107);
    offer(2'b01, 1'b1, 32'h0107_0301, 4'hF);
    step();
    wr_valid = 1'b0;
    drain("post_rst");

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
